adc_serial_streamer: RTL

//  Downstream consumer of the AVR interface's ADC sample stream and producer for its serial TX port.
//  - Scans ADC channels round-robin by driving the interface's channel select.
//  - Buffers each returned 10-bit sample with its 4-bit channel tag in a FIFO.
//  - Frames each sample into a self-synchronising 2-byte packet and streams it to the host over serial.

---
 rtl/adc_serial_streamer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/adc_serial_streamer.sv
// Round-robin ADC scanner that queues {channel, sample} entries and streams them as 2-byte serial packets.
// Define ADC_STREAM_DROP_CNT_EN to add the saturating drop_count output.
module adc_serial_streamer #(
  parameter int NUM_CHANNELS = 4,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  output logic [3:0]                    channel,
  input  logic                          new_sample,
  input  logic [9:0]                    sample,
  input  logic [3:0]                    sample_channel,
  output logic [7:0]                    tx_data,
  output logic                          new_tx_data,
  input  logic                          tx_busy,
  output logic                          overflow,
  input  logic                          clr_overflow,
`ifdef ADC_STREAM_DROP_CNT_EN
  output logic [7:0]                    drop_count,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {IDLE, HI, GAP_HI, LO, GAP_LO} state_t;

  state_t           state;
  logic [13:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [13:0]      pkt;
  logic             valid_ch;
  logic             accept;
  logic             fifo_full;
  logic             push;
  logic             drop;
  logic             pop;

  assign valid_ch  = ({1'b0, sample_channel} < 5'(NUM_CHANNELS));
  assign accept    = new_sample && enable && valid_ch;
  assign fifo_full = (fifo_level == LW'(FIFO_DEPTH));
  // A full FIFO drops the sample even when the FSM pops in the same cycle.
  assign push      = accept && !fifo_full;
  assign drop      = accept && fifo_full;
  assign pop       = (state == IDLE) && (fifo_level != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      channel <= '0;
    end else if (accept) begin
      channel <= (channel == 4'(NUM_CHANNELS - 1)) ? 4'd0 : channel + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {sample_channel, sample};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

`ifdef ADC_STREAM_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (drop) begin
      if (clr_overflow) begin
        drop_count <= 8'd1;
      end else if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end else if (clr_overflow) begin
      drop_count <= '0;
    end
  end
`endif

  // The GAP states give tx_busy one cycle to rise after each strobe before it is trusted again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pkt         <= '0;
      tx_data     <= '0;
      new_tx_data <= 1'b0;
    end else begin
      new_tx_data <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            pkt   <= mem[rd_ptr];
            state <= HI;
          end
        end
        HI: begin
          if (!tx_busy) begin
            tx_data     <= {1'b1, pkt[13:10], pkt[9:7]};
            new_tx_data <= 1'b1;
            state       <= GAP_HI;
          end
        end
        GAP_HI: state <= LO;
        LO: begin
          if (!tx_busy) begin
            tx_data     <= {1'b0, pkt[6:0]};
            new_tx_data <= 1'b1;
            state       <= GAP_LO;
          end
        end
        GAP_LO:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
